// File: rtl/cfu_rsp_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cfu_rsp_unit
//  Description : Response-side sequencer for the CFU command/response port.
//                Accepts one command at a time, launches vector ops into the
//                combinational datapath, waits a fixed per-opcode latency,
//                captures the result and holds it on the response channel
//                until the CPU takes it.
//
//  Ports
//    clk                      clock
//    reset                    synchronous active-high reset
//    cmd_valid / cmd_ready    command handshake (cmd_ready = state is IDLE)
//    cmd_payload_function_id  [2:0] opcode, [7:3] writeback register
//    cmd_payload_inputs_0     operand 0 (requested VL for vsetvli)
//    cmd_payload_inputs_1     operand 1 (not used by this unit)
//    rsp_valid / rsp_ready    response handshake
//    rsp_payload_outputs_0    response data, held until the next response
//    dp_start                 one-cycle launch strobe to the datapath
//    dp_result                datapath result, valid on the last EXEC cycle
//    busy                     high whenever the unit is not IDLE
//    illegal_cnt              saturating count of accepted opcodes 6/7
//
//  Revision    : 1.0  initial release
// ============================================================================
module cfu_rsp_unit #(
    parameter int VLMAX   = 16,
    parameter int LAT_ALU = 1,
    parameter int LAT_ACC = 2,
    parameter int LAT_MUL = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic        dp_start,
    input  logic [31:0] dp_result,
    output logic        busy,
    output logic [7:0]  illegal_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter is loaded with LAT-1 so EXEC lasts exactly LAT cycles.
    localparam logic [7:0]  c_CNT_ALU = 8'(LAT_ALU - 1);
    localparam logic [7:0]  c_CNT_ACC = 8'(LAT_ACC - 1);
    localparam logic [7:0]  c_CNT_MUL = 8'(LAT_MUL - 1);
    localparam logic [31:0] c_VLMAX   = 32'(VLMAX);

    localparam logic [2:0]  c_OP_VSETVLI = 3'd0;
    localparam logic [2:0]  c_OP_VLOAD   = 3'd1;
    localparam logic [2:0]  c_OP_VADD    = 3'd2;
    localparam logic [2:0]  c_OP_VACC    = 3'd3;
    localparam logic [2:0]  c_OP_VMUL    = 3'd4;
    localparam logic [2:0]  c_OP_VBACC   = 3'd5;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_payload;
    logic        r_dp_start;
    logic [7:0]  r_illegal_cnt;

    logic        w_accept;
    logic [2:0]  w_opcode;
    logic [31:0] w_vl;

    // Writeback register field and operand 1 belong to the decoder side.
    logic        w_unused;
    assign w_unused = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_1};

    // Handshake outputs decode the registered state only, so cmd_ready never
    // has a combinational path from rsp_ready.
    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);

    assign rsp_payload_outputs_0 = r_payload;
    assign dp_start              = r_dp_start;
    assign illegal_cnt           = r_illegal_cnt;

    assign w_accept = cmd_valid & cmd_ready;
    assign w_opcode = cmd_payload_function_id[2:0];

    // 32-bit unsigned clamp of the requested vector length.
    assign w_vl = (cmd_payload_inputs_0 > c_VLMAX) ? c_VLMAX : cmd_payload_inputs_0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= 8'd0;
            r_payload     <= 32'd0;
            r_dp_start    <= 1'b0;
            r_illegal_cnt <= 8'd0;
        end else begin
            // Launch strobe is a single-cycle pulse by default.
            r_dp_start <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (w_opcode)
                            c_OP_VSETVLI: begin
                                r_payload <= w_vl;
                                r_state   <= RESP;
                            end
                            c_OP_VLOAD: begin
                                r_payload <= 32'd0;
                                r_state   <= RESP;
                            end
                            c_OP_VADD: begin
                                r_cnt      <= c_CNT_ALU;
                                r_dp_start <= 1'b1;
                                r_state    <= EXEC;
                            end
                            c_OP_VACC, c_OP_VBACC: begin
                                r_cnt      <= c_CNT_ACC;
                                r_dp_start <= 1'b1;
                                r_state    <= EXEC;
                            end
                            c_OP_VMUL: begin
                                r_cnt      <= c_CNT_MUL;
                                r_dp_start <= 1'b1;
                                r_state    <= EXEC;
                            end
                            default: begin
                                // Opcodes 6/7: answer zero, count saturating.
                                r_payload <= 32'd0;
                                if (r_illegal_cnt != 8'hFF) begin
                                    r_illegal_cnt <= r_illegal_cnt + 8'd1;
                                end
                                r_state <= RESP;
                            end
                        endcase
                    end
                end

                EXEC: begin
                    if (r_cnt == 8'd0) begin
                        r_payload <= dp_result;
                        r_state   <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cfu_rsp_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfu_rsp_unit
//  Description : Self-checking bench for cfu_rsp_unit. Directed table of
//                single commands plus hand-written multi-cycle sequences
//                (response stall, illegal-count saturation, reset during
//                EXEC, command held while busy).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cfu_rsp_unit;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    logic        dp_start;
    logic [31:0] dp_result;
    logic        busy;
    logic [7:0]  illegal_cnt;

    int n_vec;
    int n_fail;

    cfu_rsp_unit #(
        .VLMAX   (16),
        .LAT_ALU (1),
        .LAT_ACC (2),
        .LAT_MUL (3)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .dp_start                (dp_start),
        .dp_result               (dp_result),
        .busy                    (busy),
        .illegal_cnt             (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  fid;
        logic [31:0] in0;
        logic [31:0] dp;
        int          lat;      // execute cycles (0 for non-datapath ops)
        logic [31:0] exp_pl;
        int          exp_cyc;  // cycles from accept to first rsp_valid
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One command with rsp_ready held high; dp_result carries the real value
    // only on the last EXEC cycle so the capture instant is checked.
    task automatic run_cmd(input logic [9:0] fid, input logic [31:0] in0,
                           input logic [31:0] dp, input int lat,
                           input logic [31:0] exp_pl, input int exp_cyc,
                           input string tag);
        int c;
        bit seen;
        bit alu;
        alu = (fid[2:0] >= 3'd2) && (fid[2:0] <= 3'd5);
        @(negedge clk);
        chk({tag, "_cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid               = 1'b1;
        cmd_payload_function_id = fid;
        cmd_payload_inputs_0    = in0;
        rsp_ready               = 1'b1;
        dp_result               = 32'hBAD0_0000;
        c    = 0;
        seen = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                cmd_valid               = 1'b0;
                cmd_payload_function_id = 10'($urandom);
                cmd_payload_inputs_0    = $urandom;
                chk({tag, "_dp_start_t1"}, 32'(dp_start), 32'(alu));
                chk({tag, "_cmd_ready_t1"}, 32'(cmd_ready), 32'd0);
            end
            if (c == 2) begin
                chk({tag, "_dp_start_t2"}, 32'(dp_start), 32'd0);
            end
            dp_result = (c == lat) ? dp : (32'hBAD0_0000 | 32'(c));
            if (rsp_valid) seen = 1;
        end
        chk({tag, "_latency"}, 32'(c), 32'(exp_cyc));
        chk({tag, "_payload"}, rsp_payload_outputs_0, exp_pl);
        @(negedge clk);
        chk({tag, "_rsp_valid_after"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_payload_retained"}, rsp_payload_outputs_0, exp_pl);
    endtask

    vec_t vecs[12];
    int   rsp_cnt;

    initial begin
        n_vec  = 0;
        n_fail = 0;

        vecs[0]  = '{10'h000, 32'd5,          32'h0,        0, 32'd5,         1};
        vecs[1]  = '{10'h008, 32'd40,         32'h0,        0, 32'd16,        1};
        vecs[2]  = '{10'h000, 32'd0,          32'h0,        0, 32'd0,         1};
        vecs[3]  = '{10'h0F8, 32'hFFFF_FFFF,  32'h0,        0, 32'd16,        1};
        vecs[4]  = '{10'h000, 32'd16,         32'h0,        0, 32'd16,        1};
        vecs[5]  = '{10'h000, 32'd17,         32'h0,        0, 32'd16,        1};
        vecs[6]  = '{10'h009, 32'd7,          32'h0,        0, 32'd0,         1};
        vecs[7]  = '{10'h00A, 32'd0,          32'h1234_5678, 1, 32'h1234_5678, 2};
        vecs[8]  = '{10'h013, 32'd0,          32'hA5A5_0001, 2, 32'hA5A5_0001, 3};
        vecs[9]  = '{10'h015, 32'd0,          32'h0F0F_F0F0, 2, 32'h0F0F_F0F0, 3};
        vecs[10] = '{10'h024, 32'd0,          32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 4};
        vecs[11] = '{10'h00E, 32'd99,         32'h0,        0, 32'd0,         1};

        reset                   = 1'b1;
        cmd_valid               = 1'b0;
        cmd_payload_function_id = 10'd0;
        cmd_payload_inputs_0    = 32'd0;
        cmd_payload_inputs_1    = 32'h5555_AAAA;
        rsp_ready               = 1'b0;
        dp_result               = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready",   32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid",   32'(rsp_valid), 32'd0);
        chk("reset_payload",     rsp_payload_outputs_0, 32'd0);
        chk("reset_dp_start",    32'(dp_start), 32'd0);
        chk("reset_busy",        32'(busy), 32'd0);
        chk("reset_illegal_cnt", 32'(illegal_cnt), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i].fid, vecs[i].in0, vecs[i].dp, vecs[i].lat,
                    vecs[i].exp_pl, vecs[i].exp_cyc, $sformatf("vec%0d", i));
        end
        chk("illegal_cnt_one", 32'(illegal_cnt), 32'd1);

        // vadd with the response stalled for five cycles.
        @(negedge clk);
        cmd_valid               = 1'b1;
        cmd_payload_function_id = 10'h00A;
        rsp_ready               = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("stall_dp_start", 32'(dp_start), 32'd1);
        dp_result = 32'hCAFE_F00D;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d_payload", k), rsp_payload_outputs_0, 32'hCAFE_F00D);
            chk($sformatf("stall%0d_cmd_ready", k), 32'(cmd_ready), 32'd0);
            dp_result = 32'h0BAD_0000 | 32'(k);
            @(negedge clk);
        end
        chk("stall6_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall6_payload", rsp_payload_outputs_0, 32'hCAFE_F00D);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stall_done_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("stall_done_busy", 32'(busy), 32'd0);

        // Opcode 7 issued 260 times; counter starts at 1 from vec11.
        for (int n = 0; n < 260; n++) begin
            run_cmd(10'h007, 32'(n), 32'h0, 0, 32'd0, 1, $sformatf("op7_%0d", n));
        end
        chk("illegal_cnt_sat", 32'(illegal_cnt), 32'd255);

        // Reset while vmul is in EXEC with the counter at 1.
        @(negedge clk);
        cmd_valid               = 1'b1;
        cmd_payload_function_id = 10'h024;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_exec_busy_t1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("rst_exec_busy_t2", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_exec_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_exec_busy", 32'(busy), 32'd0);
        chk("rst_exec_illegal_cnt", 32'(illegal_cnt), 32'd0);
        rsp_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            dp_result = 32'hDEAD_DEAD;
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
        end
        chk("rst_exec_no_rsp", 32'(rsp_cnt), 32'd0);

        // cmd_valid held with changing function_id while busy.
        @(negedge clk);
        cmd_valid               = 1'b1;
        cmd_payload_function_id = 10'h000;
        cmd_payload_inputs_0    = 32'd3;
        rsp_ready               = 1'b0;
        @(negedge clk);
        chk("hold_rsp_valid_b", 32'(rsp_valid), 32'd1);
        chk("hold_payload_b", rsp_payload_outputs_0, 32'd3);
        cmd_payload_function_id = 10'h007;
        cmd_payload_inputs_0    = 32'd100;
        @(negedge clk);
        chk("hold_rsp_valid_c", 32'(rsp_valid), 32'd1);
        chk("hold_cmd_ready_c", 32'(cmd_ready), 32'd0);
        cmd_payload_function_id = 10'h004;
        @(negedge clk);
        chk("hold_payload_d", rsp_payload_outputs_0, 32'd3);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        rsp_cnt   = 1;
        @(negedge clk);
        chk("hold_rsp_valid_e", 32'(rsp_valid), 32'd0);
        chk("hold_cmd_ready_e", 32'(cmd_ready), 32'd1);
        chk("hold_illegal_cnt", 32'(illegal_cnt), 32'd0);
        chk("hold_payload_e", rsp_payload_outputs_0, 32'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
        end
        chk("hold_one_rsp", 32'(rsp_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
